// File: rtl/reset_sequencer.sv
// Power-up reset sequencer. It releases the downstream resets one stage at a time and
// waits for each stage's ready. A stage that times out is retried a bounded number of times.
module reset_sequencer #(
    parameter int               NUM_STAGES  = 3,
    parameter int               CNT_W       = 22,
    parameter logic [CNT_W-1:0] STAGE_DELAY = 22'h1FFFFF,
    parameter logic [CNT_W-1:0] TIMEOUT     = 22'h3FFFFF,
    parameter int               MAX_RETRY   = 3
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic [NUM_STAGES-1:0] iREADY,
    input  logic                  iRESTART,
    output logic [NUM_STAGES-1:0] oRST,
    output logic                  oDONE,
    output logic                  oFAULT,
    output logic [1:0]            oSTAGE,
    output logic [1:0]            oRETRY
);

    typedef enum logic [1:0] {
        ST_DELAY,
        ST_WAIT_RDY,
        ST_DONE,
        ST_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] DELAY_LAST   = STAGE_DELAY - CNT_ONE;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = TIMEOUT - CNT_ONE;
    localparam logic [1:0]       STAGE_LAST   = 2'(NUM_STAGES - 1);
    localparam logic [1:0]       RETRY_LAST   = 2'(MAX_RETRY - 1);

    state_t                  stateReg, stateNext;
    logic [CNT_W-1:0]        cntReg, cntNext;
    logic [NUM_STAGES-1:0]   rstReg, rstNext;
    logic [1:0]              stageReg, stageNext;
    logic [1:0]              retryReg, retryNext;
    logic                    doneReg, doneNext;
    logic                    faultReg, faultNext;
    logic [NUM_STAGES-1:0]   stageOneHot;
    logic                    stageReady;

    // A one-hot mask of the stage being sequenced. It lets the ready select and the
    // reset update avoid a variable index that could point past NUM_STAGES.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : gStageSel
            assign stageOneHot[gi] = (stageReg == 2'(gi));
        end
    endgenerate

    assign stageReady = |(iREADY & stageOneHot);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            stateReg <= ST_DELAY;
            cntReg   <= '0;
            rstReg   <= '0;
            stageReg <= '0;
            retryReg <= '0;
            doneReg  <= 1'b0;
            faultReg <= 1'b0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            rstReg   <= rstNext;
            stageReg <= stageNext;
            retryReg <= retryNext;
            doneReg  <= doneNext;
            faultReg <= faultNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        rstNext   = rstReg;
        stageNext = stageReg;
        retryNext = retryReg;
        doneNext  = doneReg;
        faultNext = faultReg;

        case (stateReg)
            ST_DELAY: begin
                if (cntReg == DELAY_LAST) begin
                    rstNext   = rstReg | stageOneHot;
                    cntNext   = '0;
                    stateNext = ST_WAIT_RDY;
                end else begin
                    cntNext = cntReg + CNT_ONE;
                end
            end
            ST_WAIT_RDY: begin
                // Ready is checked ahead of the timeout, so a late ready on the last cycle still counts.
                if (stageReady) begin
                    if (stageReg == STAGE_LAST) begin
                        doneNext  = 1'b1;
                        stateNext = ST_DONE;
                    end else begin
                        stageNext = stageReg + 2'd1;
                        retryNext = '0;
                        cntNext   = '0;
                        stateNext = ST_DELAY;
                    end
                end else if (cntReg == TIMEOUT_LAST) begin
                    rstNext = rstReg & ~stageOneHot;
                    if (retryReg == RETRY_LAST) begin
                        faultNext = 1'b1;
                        stateNext = ST_FAULT;
                    end else begin
                        retryNext = retryReg + 2'd1;
                        cntNext   = '0;
                        stateNext = ST_DELAY;
                    end
                end else begin
                    cntNext = cntReg + CNT_ONE;
                end
            end
            ST_DONE, ST_FAULT: begin
                if (iRESTART) begin
                    rstNext   = '0;
                    doneNext  = 1'b0;
                    faultNext = 1'b0;
                    stageNext = '0;
                    retryNext = '0;
                    cntNext   = '0;
                    stateNext = ST_DELAY;
                end
            end
        endcase
    end

    assign oRST   = rstReg;
    assign oDONE  = doneReg;
    assign oFAULT = faultReg;
    assign oSTAGE = stageReg;
    assign oRETRY = retryReg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer. It runs a nominal vector table, hand-written corner sequences
// and random traffic, and checks every edge against a cycle-timestamp reference model.
module tb_reset_sequencer;

    localparam int N  = 3;
    localparam int CW = 8;
    localparam int SD = 4;
    localparam int TO = 8;
    localparam int MR = 2;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b0;
    logic [N-1:0]  iREADY = '0;
    logic          iRESTART = 1'b0;
    logic [N-1:0]  oRST;
    logic          oDONE, oFAULT;
    logic [1:0]    oSTAGE, oRETRY;

    reset_sequencer #(
        .NUM_STAGES (N),
        .CNT_W      (CW),
        .STAGE_DELAY(8'(SD)),
        .TIMEOUT    (8'(TO)),
        .MAX_RETRY  (MR)
    ) dut (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iREADY  (iREADY),
        .iRESTART(iRESTART),
        .oRST    (oRST),
        .oDONE   (oDONE),
        .oFAULT  (oFAULT),
        .oSTAGE  (oSTAGE),
        .oRETRY  (oRETRY)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [N-1:0] ready;
        logic         restart;
        logic [8:0]   exp;
    } vec_t;

    vec_t vecs [17];

    int nChecks = 0;
    int nFail   = 0;
    int n;

    // Reference model: the position within a phase is the elapsed edge count since the phase began.
    int           cyc;
    int           mStart;
    int           mStage;
    int           mRetry;
    logic [N-1:0] mRst;
    bit           mDone;
    bit           mFault;

    function automatic logic [8:0] pack(logic [2:0] r, logic d, logic f, logic [1:0] s, logic [1:0] t);
        return {r, d, f, s, t};
    endfunction

    function automatic vec_t mkVec(logic [2:0] ready, logic restart, logic [2:0] r, logic d, logic [1:0] s);
        vec_t v;
        v.ready   = ready;
        v.restart = restart;
        v.exp     = pack(r, d, 1'b0, s, 2'd0);
        return v;
    endfunction

    function automatic logic [8:0] got();
        return {oRST, oDONE, oFAULT, oSTAGE, oRETRY};
    endfunction

    function automatic logic [8:0] modelVec();
        return {mRst, mDone, mFault, 2'(mStage), 2'(mRetry)};
    endfunction

    task automatic modelClear();
        mRst   = '0;
        mDone  = 1'b0;
        mFault = 1'b0;
        mStage = 0;
        mRetry = 0;
        mStart = cyc;
    endtask

    task automatic modelEdge();
        cyc++;
        if (mDone || mFault) begin
            if (iRESTART) modelClear();
        end else if (!mRst[mStage]) begin
            if (cyc - mStart == SD) begin
                mRst[mStage] = 1'b1;
                mStart       = cyc;
            end
        end else if (iREADY[mStage]) begin
            if (mStage == N - 1) begin
                mDone = 1'b1;
            end else begin
                mStage++;
                mRetry = 0;
                mStart = cyc;
            end
        end else if (cyc - mStart == TO) begin
            mRst[mStage] = 1'b0;
            if (mRetry + 1 == MR) begin
                mFault = 1'b1;
            end else begin
                mRetry++;
                mStart = cyc;
            end
        end
    endtask

    task automatic check(string name, logic [8:0] act, logic [8:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got rst=%b done=%b fault=%b stage=%0d retry=%0d, required rst=%b done=%b fault=%b stage=%0d retry=%0d",
                     name, act[8:6], act[5], act[4], act[3:2], act[1:0],
                     exp[8:6], exp[5], exp[4], exp[3:2], exp[1:0]);
        end
    endtask

    task automatic checkInt(string name, int act, int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick(string tag);
        @(posedge iCLK);
        #1;
        if (!iRST) begin
            cyc = 0;
            modelClear();
        end else begin
            modelEdge();
        end
        check(tag, got(), modelVec());
    endtask

    task automatic releaseReset();
        iRST = 1'b1;
        cyc  = 0;
        modelClear();
    endtask

    initial begin
        // Nominal sequence with all stages ready, edge by edge after reset release.
        vecs[0]  = mkVec(3'b111, 1'b0, 3'b000, 1'b0, 2'd0);
        vecs[1]  = mkVec(3'b111, 1'b0, 3'b000, 1'b0, 2'd0);
        vecs[2]  = mkVec(3'b111, 1'b0, 3'b000, 1'b0, 2'd0);
        vecs[3]  = mkVec(3'b111, 1'b0, 3'b001, 1'b0, 2'd0);
        vecs[4]  = mkVec(3'b111, 1'b0, 3'b001, 1'b0, 2'd1);
        vecs[5]  = mkVec(3'b111, 1'b0, 3'b001, 1'b0, 2'd1);
        vecs[6]  = mkVec(3'b111, 1'b0, 3'b001, 1'b0, 2'd1);
        vecs[7]  = mkVec(3'b111, 1'b0, 3'b001, 1'b0, 2'd1);
        vecs[8]  = mkVec(3'b111, 1'b0, 3'b011, 1'b0, 2'd1);
        vecs[9]  = mkVec(3'b111, 1'b0, 3'b011, 1'b0, 2'd2);
        vecs[10] = mkVec(3'b111, 1'b0, 3'b011, 1'b0, 2'd2);
        vecs[11] = mkVec(3'b111, 1'b0, 3'b011, 1'b0, 2'd2);
        vecs[12] = mkVec(3'b111, 1'b0, 3'b011, 1'b0, 2'd2);
        vecs[13] = mkVec(3'b111, 1'b0, 3'b111, 1'b0, 2'd2);
        vecs[14] = mkVec(3'b111, 1'b0, 3'b111, 1'b1, 2'd2);
        vecs[15] = mkVec(3'b000, 1'b0, 3'b111, 1'b1, 2'd2);
        vecs[16] = mkVec(3'b000, 1'b0, 3'b111, 1'b1, 2'd2);

        cyc = 0;
        modelClear();
        repeat (3) tick("in_reset_model");
        check("reset_state", got(), 9'd0);

        releaseReset();
        for (int i = 0; i < 17; i++) begin
            iREADY   = vecs[i].ready;
            iRESTART = vecs[i].restart;
            tick("nominal_model");
            check("nominal_vec", got(), vecs[i].exp);
            $display("vec %0d: ready=%b rst=%b done=%b stage=%0d", i, iREADY, oRST, oDONE, oSTAGE);
        end

        // Restart from DONE, then a restart pulse during WAIT_RDY, then the ready/timeout race.
        iRESTART = 1'b1;
        iREADY   = 3'b111;
        tick("restart_done_model");
        iRESTART = 1'b0;
        check("restart_from_done", got(), 9'd0);
        iREADY = 3'b000;
        repeat (4) tick("delay0_model");
        check("release0_after_restart", got(), pack(3'b001, 1'b0, 1'b0, 2'd0, 2'd0));
        iRESTART = 1'b1;
        tick("wait_restart_model");
        iRESTART = 1'b0;
        check("restart_in_wait_ignored", got(), pack(3'b001, 1'b0, 1'b0, 2'd0, 2'd0));
        repeat (6) tick("wait0_model");
        iREADY = 3'b001;
        tick("race_model");
        check("race_ready_wins", got(), pack(3'b001, 1'b0, 1'b0, 2'd1, 2'd0));
        $display("race: rst=%b stage=%0d retry=%0d", oRST, oSTAGE, oRETRY);

        // A single timeout on stage 1. Its ready arrives 3 cycles after the second release.
        iREADY = 3'b101;
        n = 0;
        while (oRETRY != 2'd1 && n < 40) begin tick("timeout_wait_model"); n++; end
        check("single_timeout", got(), pack(3'b001, 1'b0, 1'b0, 2'd1, 2'd1));
        n = 0;
        do begin tick("redelay_model"); n++; end while (!oRST[1] && n < 20);
        checkInt("re_release_delay", n, SD);
        repeat (2) tick("late_ready_model");
        iREADY = 3'b111;
        n = 0;
        while (!oDONE && n < 40) begin tick("finish_model"); n++; end
        check("timeout_then_done", got(), pack(3'b111, 1'b1, 1'b0, 2'd2, 2'd0));
        $display("timeout: done=%b stage=%0d", oDONE, oSTAGE);

        // Stage 1 stuck not-ready until the fault.
        iRESTART = 1'b1;
        tick("restart2_model");
        iRESTART = 1'b0;
        iREADY = 3'b101;
        n = 0;
        while (!oFAULT && n < 100) begin tick("fault_wait_model"); n++; end
        check("fault_entry", got(), pack(3'b001, 1'b0, 1'b1, 2'd1, 2'd1));
        iREADY = 3'b111;
        repeat (20) tick("fault_hold_model");
        check("fault_hold", got(), pack(3'b001, 1'b0, 1'b1, 2'd1, 2'd1));
        iRESTART = 1'b1;
        tick("restart_fault_model");
        iRESTART = 1'b0;
        check("restart_from_fault", got(), 9'd0);
        n = 0;
        do begin tick("delay_after_fault_model"); n++; end while (!oRST[0] && n < 20);
        checkInt("release0_after_fault", n, SD);
        $display("fault/restart: rst=%b stage=%0d", oRST, oSTAGE);

        // Asynchronous reset while stage 1 is in WAIT_RDY.
        iREADY = 3'b101;
        repeat (5) tick("to_stage1_wait_model");
        check("stage1_waiting", got(), pack(3'b011, 1'b0, 1'b0, 2'd1, 2'd0));
        #3;
        iRST = 1'b0;
        #1;
        check("async_reset", got(), 9'd0);
        cyc = 0;
        modelClear();
        repeat (2) tick("held_model");
        releaseReset();
        iREADY = 3'b111;
        n = 0;
        do begin tick("after_reset_model"); n++; end while (!oDONE && n < 40);
        checkInt("done_after_reset", n, 15);
        $display("async reset: done after %0d edges", n);

        // Random traffic. Ready density is re-drawn every 40 cycles to provoke timeouts and faults.
        begin
            int unsigned thresh;
            thresh = 5;
            for (int t = 0; t < 3000; t++) begin
                if (t % 40 == 0) thresh = $urandom_range(0, 10);
                for (int b = 0; b < N; b++) iREADY[b] = ($urandom_range(0, 9) < thresh);
                iRESTART = ($urandom_range(0, 15) == 0);
                tick("random_model");
            end
            iRESTART = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Power-up reset controller for the camera-to-VGA pipeline.
- Releases up to 4 downstream subsystems in strict order. Typical order: SDRAM controller, camera I2C config, capture/VGA datapath.
- Each stage's reset is released only after a programmable delay. The next stage waits for that stage's ready acknowledge.
- Handles per-stage timeout with bounded retry, raises a fault flag, and supports software-requested re-sequencing.

Parameters:
- NUM_STAGES, 3, number of sequenced reset outputs (1..4).
- CNT_W, 22, width of the shared delay/timeout counter.
- STAGE_DELAY, 22'h1FFFFF, cycles spent in DELAY before a stage's reset is released (≥1).
- TIMEOUT, 22'h3FFFFF, cycles allowed in WAIT_RDY for iREADY before declaring timeout (≥1).
- MAX_RETRY, 3, timeouts tolerated per stage before FAULT (≥1).

Ports:
- iCLK  in  1  system clock.
- iRST  in  1  asynchronous active-low reset.
- iREADY  in  NUM_STAGES  per-stage ready/init-done; level, synchronous to iCLK.
- iRESTART  in  1  single-cycle pulse requesting a full re-sequence; honoured only in DONE or FAULT.
- oRST  out  NUM_STAGES  per-stage reset, active-low to downstream (0 = held in reset, 1 = released).
- oDONE  out  1  all stages released and acknowledged.
- oFAULT  out  1  retry budget exhausted on some stage.
- oSTAGE  out  2  index of the stage currently being sequenced or faulted.
- oRETRY  out  2  timeouts taken so far on the current stage.

Behaviour:
- Async reset (iRST=0) drives every output to 0: oRST=0, oDONE=0, oFAULT=0, oSTAGE=0, oRETRY=0.
  - Internal state goes to DELAY, counter 0.
  - Reset may assert in any state; effect is immediate.
- States: DELAY, WAIT_RDY, DONE, FAULT. Registered outputs, one-hot or binary encoding free.
- DELAY:
  - Counter increments by 1 per cycle.
  - When counter == STAGE_DELAY-1: set oRST[oSTAGE]=1, clear counter, go to WAIT_RDY.
  - Result: oRST[k] rises exactly STAGE_DELAY cycles after DELAY is entered.
- WAIT_RDY:
  - Counter increments each cycle. iREADY[oSTAGE] is sampled each cycle.
  - If ready and oSTAGE == NUM_STAGES-1: go to DONE, oDONE=1 next cycle.
  - If ready otherwise: oSTAGE++, oRETRY=0, counter=0, go to DELAY.
  - If not ready and counter == TIMEOUT-1 (timeout):
    - oRST[oSTAGE] returns to 0; earlier stages stay released.
    - If oRETRY == MAX_RETRY-1: go to FAULT, oFAULT=1, oSTAGE holds the failing index.
    - Else: oRETRY++, counter=0, go to DELAY for the same stage.
  - Ready and timeout in the same cycle: ready wins.
- DONE:
  - All oRST=1, oDONE=1.
  - Later changes on iREADY are ignored.
  - Counter is frozen, no wrap.
- FAULT:
  - oFAULT=1 held.
  - Stages below oSTAGE stay released; oSTAGE and above are 0.
- iRESTART in DONE or FAULT:
  - Next cycle: all oRST=0, oDONE=0, oFAULT=0, oSTAGE=0, oRETRY=0, counter=0, state DELAY.
- iRESTART in DELAY or WAIT_RDY: ignored.
- oRST bits never glitch; each changes only on the transitions listed above.
- Counter never exceeds max(STAGE_DELAY, TIMEOUT)-1 and never wraps.
- iREADY for stages not yet being sequenced is ignored.

Test Plan (NUM_STAGES=3, STAGE_DELAY=4, TIMEOUT=8, MAX_RETRY=2):
- Nominal: release iRST, tie iREADY=3'b111.
  - oRST[0] rises at edge 4, oRST[1] at edge 9, oRST[2] at edge 14.
  - oDONE=1 at edge 15; oSTAGE=2, oRETRY=0.
- Single timeout: iREADY[1]=0 until 3 cycles after its second release.
  - oRST[1] drops after 8 WAIT cycles; oRETRY=1.
  - oRST[1] re-rises 4 cycles later; sequence completes with oDONE=1.
- Fault: iREADY[1] stuck 0.
  - After 2 timeouts: oFAULT=1, oSTAGE=1, oRST=3'b001, oDONE=0; state holds indefinitely.
- Restart: pulse iRESTART in FAULT, then in DONE.
  - Each time, next cycle oRST=0, flags cleared.
  - Nominal timing repeats from 0; pulse during WAIT_RDY has no effect.
- Race: raise iREADY[0] exactly on the cycle the counter hits TIMEOUT-1.
  - Stage advances; no retry counted, oRST[0] stays 1.
- Mid-sequence reset: assert iRST asynchronously (between edges) during stage-1 WAIT_RDY.
  - All outputs 0 immediately.
  - After release, sequence restarts from stage 0 with nominal timing.
